// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pipe_ctrl_pkg
// Purpose  : Shared FSM state encoding and default parameters for pipe_ctrl.
// Revision : 1.0
// ============================================================================
package pipe_ctrl_pkg;

    localparam int NUM_STAGES_DEF  = 5;
    localparam int REDIR_STAGE_DEF = 2;
    localparam int CNT_W_DEF       = 32;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    typedef enum logic [0:0] {
        RUN  = ST_RUN,
        PEND = ST_PEND
    } pipe_state_e;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating up-counter with synchronous clear.
// Revision : 1.0
// ============================================================================
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment; the count sticks once it reaches all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline stall/flush/redirect controller with perf counters.
// Revision : 1.0
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES  = NUM_STAGES_DEF,
    parameter int REDIR_STAGE = REDIR_STAGE_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic                  ld_use_haz,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    input  logic                  perf_clr,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_flush,
    output logic                  pc_redir_we,
    output logic [31:0]           pc_redir,
    output logic [CNT_W-1:0]      cyc_cnt,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    pipe_state_e state_q;
    pipe_state_e state_d;
    logic [31:0] pend_q;
    logic [31:0] pend_d;

    logic                  redir_ok;
    logic                  redir_acc;
    logic                  redir_flush;
    logic                  ld_eff;
    logic [NUM_STAGES-1:0] stall_eff;

    // Acceptance looks only at external stalls at or beyond the resolving
    // stage, so the load-use override below cannot feed back into it.
    assign redir_ok    = ~|stall_req[NUM_STAGES-1:REDIR_STAGE];
    assign redir_acc   = (state_q == RUN) && redirect_valid && redir_ok;
    assign redir_flush = redir_acc || (state_q == PEND);
    assign ld_eff      = ld_use_haz && !redir_acc;

    always_comb begin
        stall_eff    = stall_req;
        stall_eff[1] = stall_req[1] | ld_eff;
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_en
        assign stage_en[k] = ~|stall_eff[NUM_STAGES-1:k];
    end

    assign stage_flush[0] = 1'b0;

    // A bubble goes in behind a frozen stage, and over the wrong-path stages
    // while a redirect is being accepted or is still waiting for the PC.
    for (genvar k = 1; k < NUM_STAGES; k++) begin : g_flush
        assign stage_flush[k] = (~stage_en[k-1] & stage_en[k])
                              | (redir_flush & (k <= REDIR_STAGE));
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pc_redir_we = 1'b0;
        pc_redir    = 32'h0;
        case (state_q)
            RUN: begin
                if (redir_acc) begin
                    if (stage_en[0]) begin
                        pc_redir_we = 1'b1;
                        pc_redir    = redirect_pc;
                    end else begin
                        pend_d  = redirect_pc;
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (stage_en[0]) begin
                    pc_redir_we = 1'b1;
                    pc_redir    = pend_q;
                    state_d     = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pend_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk (clk),
        .rst (rst),
        .inc (1'b1),
        .clr (perf_clr),
        .cnt (cyc_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (~stage_en[0]),
        .clr (perf_clr),
        .cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (redir_acc),
        .clr (perf_clr),
        .cnt (flush_cnt)
    );

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Directed and randomized checks of pipe_ctrl against a reference.
// Revision : 1.0
// ============================================================================
module tb_pipe_ctrl;

    localparam int NS = 5;
    localparam int RS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] stall_req;
    logic          ld_use_haz;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          perf_clr;

    logic [NS-1:0] stage_en, stage_flush;
    logic          pc_redir_we;
    logic [31:0]   pc_redir;
    logic [31:0]   cyc_cnt, stall_cnt, flush_cnt;

    logic [NS-1:0] en4, fl4;
    logic          we4;
    logic [31:0]   pc4;
    logic [3:0]    cyc4, st4, fc4;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: pending redirect and true event counts since clear.
    bit            m_pend;
    logic [31:0]   m_pend_pc;
    longint        t_cyc, t_stall, t_flush;
    logic [NS-1:0] e_en, e_flush;
    logic          e_we, e_acc;
    logic [31:0]   e_pc;

    always #5 clk = ~clk;

    pipe_ctrl #(.NUM_STAGES(NS), .REDIR_STAGE(RS), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall_req(stall_req), .ld_use_haz(ld_use_haz),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .perf_clr(perf_clr),
        .stage_en(stage_en), .stage_flush(stage_flush), .pc_redir_we(pc_redir_we),
        .pc_redir(pc_redir), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl #(.NUM_STAGES(NS), .REDIR_STAGE(RS), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall_req(stall_req), .ld_use_haz(ld_use_haz),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .perf_clr(perf_clr),
        .stage_en(en4), .stage_flush(fl4), .pc_redir_we(we4),
        .pc_redir(pc4), .cyc_cnt(cyc4), .stall_cnt(st4), .flush_cnt(fc4)
    );

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_eval();
        bit stl[NS];
        bit ok;
        ok = 1;
        for (int k = RS; k < NS; k++) if (stall_req[k]) ok = 0;
        e_acc = !m_pend && redirect_valid && ok;
        for (int k = 0; k < NS; k++) stl[k] = stall_req[k];
        if (ld_use_haz && !e_acc) stl[1] = 1;
        for (int k = 0; k < NS; k++) begin
            e_en[k] = 1'b1;
            for (int j = k; j < NS; j++) if (stl[j]) e_en[k] = 1'b0;
        end
        e_flush = '0;
        for (int k = 1; k < NS; k++)
            e_flush[k] = (!e_en[k-1] && e_en[k]) || ((e_acc || m_pend) && k <= RS);
        e_we = 1'b0;
        e_pc = 32'h0;
        if ((e_acc || m_pend) && e_en[0]) begin
            e_we = 1'b1;
            e_pc = m_pend ? m_pend_pc : redirect_pc;
        end
    endtask

    task automatic advance();
        if (rst) begin
            if (e_acc && !e_en[0]) begin
                m_pend    = 1;
                m_pend_pc = redirect_pc;
            end else if (m_pend && e_en[0]) begin
                m_pend = 0;
            end
            if (perf_clr) begin
                t_cyc = 0; t_stall = 0; t_flush = 0;
            end else begin
                t_cyc++;
                if (!e_en[0]) t_stall++;
                if (e_acc) t_flush++;
            end
        end
    endtask

    task automatic apply(input logic r, input logic [NS-1:0] s, input logic ld,
                         input logic rv, input logic [31:0] rpc, input logic clr);
        @(negedge clk);
        rst = r; stall_req = s; ld_use_haz = ld;
        redirect_valid = rv; redirect_pc = rpc; perf_clr = clr;
        if (!r) begin
            m_pend = 0; m_pend_pc = 32'h0;
            t_cyc = 0; t_stall = 0; t_flush = 0;
        end
        #1;
        model_eval();
    endtask

    task automatic test_reset();
        apply(0, '0, 0, 0, 32'h0, 0);
        n_cmp++; if (cyc_cnt !== 32'h0) begin n_err++; $display("FAIL rst_cyc: got %0d want 0", cyc_cnt); end
        n_cmp++; if (stall_cnt !== 32'h0 || flush_cnt !== 32'h0) begin n_err++; $display("FAIL rst_cnts: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        n_cmp++; if (stage_en !== 5'b11111 || stage_flush !== 5'b00000) begin n_err++; $display("FAIL rst_en_flush: got %b/%b want 11111/00000", stage_en, stage_flush); end
        n_cmp++; if (pc_redir_we !== 1'b0 || pc_redir !== 32'h0) begin n_err++; $display("FAIL rst_redir: got %b/%h want 0/0", pc_redir_we, pc_redir); end
        advance();
        apply(0, '0, 0, 0, 32'h0, 0);
        advance();
        apply(1, '0, 0, 0, 32'h0, 0);
        n_cmp++; if (cyc_cnt !== 32'd0) begin n_err++; $display("FAIL rst_release_cyc: got %0d want 0", cyc_cnt); end
        advance();
        apply(1, '0, 0, 0, 32'h0, 0);
        n_cmp++; if (cyc_cnt !== 32'd1) begin n_err++; $display("FAIL cyc_first_inc: got %0d want 1", cyc_cnt); end
        advance();
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) begin
            apply(1, 5'b01000, 0, 0, 32'h0, 0);
            n_cmp++; if (stage_en !== 5'b10000 || stage_flush !== 5'b10000) begin n_err++; $display("FAIL dm_stall: got en %b flush %b want 10000/10000", stage_en, stage_flush); end
            n_cmp++; if (stall_cnt !== 32'(t_stall)) begin n_err++; $display("FAIL dm_stall_cnt: got %0d want %0d", stall_cnt, t_stall); end
            advance();
        end
    endtask

    task automatic test_ld_use();
        apply(1, '0, 1, 0, 32'h0, 0);
        n_cmp++; if (stage_en !== 5'b11100 || stage_flush !== 5'b00100) begin n_err++; $display("FAIL ld_use: got en %b flush %b want 11100/00100", stage_en, stage_flush); end
        advance();
    endtask

    task automatic test_redirect();
        apply(1, '0, 0, 1, 32'h100, 0);
        n_cmp++; if (pc_redir_we !== 1'b1 || pc_redir !== 32'h100) begin n_err++; $display("FAIL redir: got we %b pc %h want 1/00000100", pc_redir_we, pc_redir); end
        n_cmp++; if (stage_flush !== 5'b00110) begin n_err++; $display("FAIL redir_flush: got %b want 00110", stage_flush); end
        advance();
        apply(1, '0, 0, 0, 32'h0, 0);
        n_cmp++; if (flush_cnt !== 32'(t_flush) || pc_redir !== 32'h0) begin n_err++; $display("FAIL redir_after: got cnt %0d pc %h want %0d/0", flush_cnt, pc_redir, t_flush); end
        advance();
    endtask

    task automatic test_pend();
        apply(1, 5'b00001, 0, 0, 32'h0, 0);
        advance();
        apply(1, 5'b00001, 0, 1, 32'h200, 0);
        n_cmp++; if (pc_redir_we !== 1'b0 || stage_flush !== 5'b00110) begin n_err++; $display("FAIL pend_enter: got we %b flush %b want 0/00110", pc_redir_we, stage_flush); end
        advance();
        apply(1, 5'b00001, 0, 1, 32'h300, 0);
        n_cmp++; if (pc_redir_we !== 1'b0 || stage_flush !== 5'b00110) begin n_err++; $display("FAIL pend_hold: got we %b flush %b want 0/00110", pc_redir_we, stage_flush); end
        advance();
        apply(1, 5'b00000, 0, 0, 32'h0, 0);
        n_cmp++; if (pc_redir_we !== 1'b1 || pc_redir !== 32'h200 || stage_flush !== 5'b00110) begin n_err++; $display("FAIL pend_exit: got we %b pc %h flush %b want 1/00000200/00110", pc_redir_we, pc_redir, stage_flush); end
        advance();
        apply(1, 5'b00000, 0, 0, 32'h0, 0);
        n_cmp++; if (pc_redir_we !== 1'b0 || stage_flush !== 5'b00000) begin n_err++; $display("FAIL pend_back_run: got we %b flush %b want 0/00000", pc_redir_we, stage_flush); end
        n_cmp++; if (flush_cnt !== 32'(t_flush)) begin n_err++; $display("FAIL pend_flush_cnt: got %0d want %0d", flush_cnt, t_flush); end
        advance();
    endtask

    task automatic test_redir_ld();
        apply(1, '0, 1, 1, 32'h180, 0);
        n_cmp++; if (stage_en !== 5'b11111 || stage_flush !== 5'b00110) begin n_err++; $display("FAIL redir_ld: got en %b flush %b want 11111/00110", stage_en, stage_flush); end
        n_cmp++; if (pc_redir_we !== 1'b1 || pc_redir !== 32'h180) begin n_err++; $display("FAIL redir_ld_pc: got we %b pc %h want 1/00000180", pc_redir_we, pc_redir); end
        advance();
    endtask

    task automatic test_sat_clr();
        apply(1, '0, 0, 0, 32'h0, 1);
        advance();
        for (int i = 0; i < 20; i++) begin
            apply(1, 5'b00001, 0, 0, 32'h0, 0);
            advance();
        end
        apply(1, 5'b00001, 0, 0, 32'h0, 1);
        n_cmp++; if (st4 !== 4'hF || cyc4 !== 4'hF) begin n_err++; $display("FAIL sat4: got stall %h cyc %h want F/F", st4, cyc4); end
        n_cmp++; if (stall_cnt !== 32'd20) begin n_err++; $display("FAIL sat32_stall: got %0d want 20", stall_cnt); end
        advance();
        apply(1, '0, 0, 0, 32'h0, 0);
        n_cmp++; if (st4 !== 4'h0 || cyc4 !== 4'h0 || fc4 !== 4'h0 || cyc_cnt !== 32'h0) begin n_err++; $display("FAIL perf_clr: got %h/%h/%h/%0d want 0/0/0/0", st4, cyc4, fc4, cyc_cnt); end
        advance();
    endtask

    task automatic test_reset_in_pend();
        apply(1, 5'b00001, 0, 1, 32'h3C0, 0);
        n_cmp++; if (pc_redir_we !== 1'b0) begin n_err++; $display("FAIL rp_enter: got we %b want 0", pc_redir_we); end
        advance();
        apply(0, 5'b00001, 0, 0, 32'h0, 0);
        n_cmp++; if (stage_flush !== 5'b00010 || pc_redir_we !== 1'b0) begin n_err++; $display("FAIL rp_in_reset: got flush %b we %b want 00010/0", stage_flush, pc_redir_we); end
        advance();
        apply(1, '0, 0, 0, 32'h0, 0);
        n_cmp++; if (pc_redir_we !== 1'b0 || pc_redir !== 32'h0 || stage_flush !== 5'b00000) begin n_err++; $display("FAIL rp_discard: got we %b pc %h flush %b want 0/0/00000", pc_redir_we, pc_redir, stage_flush); end
        advance();
    endtask

    task automatic test_random();
        logic [NS-1:0] s;
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
            apply(($urandom_range(0, 79) != 0), s, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), $urandom, ($urandom_range(0, 39) == 0));
            n_cmp++; if (stage_en !== e_en) begin n_err++; $display("FAIL rnd_en[%0d]: got %b want %b", i, stage_en, e_en); end
            n_cmp++; if (stage_flush !== e_flush) begin n_err++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, stage_flush, e_flush); end
            n_cmp++; if (pc_redir_we !== e_we || pc_redir !== e_pc) begin n_err++; $display("FAIL rnd_redir[%0d]: got %b/%h want %b/%h", i, pc_redir_we, pc_redir, e_we, e_pc); end
            n_cmp++; if (cyc_cnt !== 32'(sat(t_cyc, 32)) || cyc4 !== 4'(sat(t_cyc, 4))) begin n_err++; $display("FAIL rnd_cyc[%0d]: got %0d/%0d want %0d", i, cyc_cnt, cyc4, t_cyc); end
            n_cmp++; if (stall_cnt !== 32'(sat(t_stall, 32)) || st4 !== 4'(sat(t_stall, 4))) begin n_err++; $display("FAIL rnd_stall[%0d]: got %0d/%0d want %0d", i, stall_cnt, st4, t_stall); end
            n_cmp++; if (flush_cnt !== 32'(sat(t_flush, 32)) || fc4 !== 4'(sat(t_flush, 4))) begin n_err++; $display("FAIL rnd_flushcnt[%0d]: got %0d/%0d want %0d", i, flush_cnt, fc4, t_flush); end
            advance();
        end
    endtask

    initial begin
        rst = 1'b0; stall_req = '0; ld_use_haz = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; perf_clr = 1'b0;
        m_pend = 0; m_pend_pc = 32'h0; t_cyc = 0; t_stall = 0; t_flush = 0;
        test_reset();
        test_stall();
        test_ld_use();
        test_redirect();
        test_pend();
        test_redir_ld();
        test_sat_clr();
        test_reset_in_pend();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pipe_ctrl
`default_nettype wire
